// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IF/D memory port arbiter.
package mem_arb_pkg;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2
   } arb_state_e;

   localparam int ADDR_W_DEF      = 32;
   localparam int DATA_W_DEF      = 32;
   localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/arb_prio_sel.sv
// Two-way requester selector. ARB_ROUND_ROBIN_EN selects alternating tie-break;
// otherwise D wins every tie.
module arb_prio_sel
   import mem_arb_pkg::*;
(
   input  logic   if_req,
   input  logic   d_req,
   input  owner_e last_owner,
   output owner_e winner
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      winner = OWN_IF;
      if (if_req && d_req)
         winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
      else if (d_req)
         winner = OWN_D;
   end
`else
   // Only consulted when at least one request is up, so D alone decides.
   logic unused_sel;
   assign unused_sel = if_req ^ last_owner;

   always_comb begin
      winner = OWN_IF;
      if (d_req)
         winner = OWN_D;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, one outstanding
// transaction, with response timeout. Tie-break mode set by ARB_ROUND_ROBIN_EN.
//
// state    | meaning
// ARB_IDLE | no transaction; arbitrate when a request is present
// ARB_REQ  | presenting owner's request to memory until mem_gnt
// ARB_WAIT | waiting for mem_rvalid or timeout
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                rsp_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic                mem_gnt,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

   arb_state_e       state;
   owner_e           owner;
   owner_e           winner;
   owner_e           last_owner;
   logic [CNT_W-1:0] cnt;
   logic             timed_out;

   arb_prio_sel u_sel (
      .if_req     (if_req),
      .d_req      (d_req),
      .last_owner (last_owner),
      .winner     (winner)
   );

   assign timed_out = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ARB_IDLE;
         owner <= OWN_IF;
         cnt   <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (if_req || d_req) begin
                  owner <= winner;
                  state <= ARB_REQ;
               end
            end
            ARB_REQ: begin
               if (mem_gnt) begin
                  cnt   <= '0;
                  state <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (mem_rvalid || timed_out)
                  state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         last_owner <= OWN_IF;
      else if (state == ARB_REQ && mem_gnt)
         last_owner <= owner;
   end
`else
   assign last_owner = OWN_IF;
`endif

   // Everything below is combinational so grants and responses appear in the
   // same cycle as mem_gnt / mem_rvalid.
   always_comb begin
      logic             in_req;
      logic             in_wait;
      logic             own_d;
      logic             rsp_fire;
      logic [DATA_W-1:0] rsp_data;

      in_req   = (state == ARB_REQ);
      in_wait  = (state == ARB_WAIT);
      own_d    = (owner == OWN_D);
      rsp_fire = in_wait && (mem_rvalid || timed_out);
      rsp_data = (in_wait && mem_rvalid) ? mem_rdata : '0;

      if_gnt    = in_req && mem_gnt && !own_d;
      d_gnt     = in_req && mem_gnt && own_d;
      if_rvalid = rsp_fire && !own_d;
      d_rvalid  = rsp_fire && own_d;
      if_rdata  = own_d ? '0 : rsp_data;
      d_rdata   = own_d ? rsp_data : '0;
      rsp_err   = in_wait && !mem_rvalid && timed_out;

      mem_req   = in_req;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (in_req) begin
         if (own_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
         end else begin
            mem_addr  = if_addr;
            mem_be    = {BE_W{1'b1}};
         end
      end

      busy = (state != ARB_IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand sequences and
// randomized transactions against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be, mem_be;
   logic        rsp_err, mem_req, mem_we, mem_gnt, mem_rvalid, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_pass  = 0;
   int n_total = 0;
   bit last_d  = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .rsp_err(rsp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
   );

   typedef struct {
      bit          if_r;
      bit          d_r;
      bit          d_we;
      logic [31:0] if_addr;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_be;
      int          gdly;
      int          rdly;
      logic [31:0] rdata;
      bit          late_d;
      bit          exp_first_d;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference arbitration rule: single requester wins; tie goes to D (fixed)
   // or to whoever did not win last (round robin).
   function automatic bit pick_d(bit ir, bit dr, bit last);
      if (ir && dr) return RR ? !last : 1'b1;
      return dr;
   endfunction

   // Entered at a negedge with state IDLE and the requests already driven.
   // Returns at the negedge of the IDLE cycle that follows the response.
   task automatic do_txn(input bit is_d, input int gdly, input int rdly,
                         input logic [31:0] rd, input bit late_d);
      logic [31:0] ea, ewd;
      logic [3:0]  ebe;
      logic        ewe;
      bit          exp_v, exp_err;
      ea  = is_d ? d_addr  : if_addr;
      ewe = is_d ? d_we    : 1'b0;
      ewd = is_d ? d_wdata : 32'h0;
      ebe = is_d ? d_be    : 4'hF;
      for (int g = 0; g <= gdly; g++) begin
         @(negedge clk);
         mem_gnt    = (g == gdly);
         mem_rvalid = 1'b1;
         if (late_d && g == 1) d_req = 1'b1;
         #1;
         chk("req_mem_req", mem_req, 1'b1);
         chk("req_addr", mem_addr, ea);
         chk("req_we_be_wd", {mem_we, mem_be, mem_wdata}, {ewe, ebe, ewd});
         chk("req_gnt", {if_gnt, d_gnt}, (g == gdly) ? (is_d ? 2'b01 : 2'b10) : 2'b00);
         chk("req_no_rvalid", {if_rvalid, d_rvalid}, 2'b00);
      end
      exp_err = (rdly > TO);
      for (int k = 1; k <= TO + 2; k++) begin
         @(negedge clk);
         mem_gnt = 1'b1;
         if (is_d) d_req = 1'b0; else if_req = 1'b0;
         mem_rvalid = (k == rdly);
         mem_rdata  = (k == rdly) ? rd : $urandom;
         exp_v = (k == rdly) || (exp_err && k == TO);
         #1;
         chk("wait_mem_req", {mem_req, busy}, 2'b01);
         chk("wait_rvalid", {if_rvalid, d_rvalid}, exp_v ? (is_d ? 2'b01 : 2'b10) : 2'b00);
         chk("wait_gnt_quiet", {if_gnt, d_gnt}, 2'b00);
         if (exp_v) begin
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_rdata", is_d ? d_rdata : if_rdata, exp_err ? 32'h0 : rd);
            break;
         end
      end
      @(negedge clk);
      mem_rvalid = 1'b1;
      mem_gnt    = 1'b1;
      #1;
      chk("idle_after_rsp", {busy, mem_req, if_rvalid, d_rvalid, if_gnt, d_gnt}, 6'b0);
      mem_rvalid = 1'b0;
      mem_gnt    = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int gdly2, input int rdly2, input logic [31:0] rd2);
      bit wd;
      bit first = 1'b1;
      if_req = v.if_r; if_addr = v.if_addr;
      d_req = v.d_r; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata; d_be = v.d_be;
      for (int n = 0; n < 3 && (if_req || d_req); n++) begin
         wd = pick_d(if_req, d_req, last_d);
         if (first) chk("first_owner", wd, v.exp_first_d);
         do_txn(wd, first ? v.gdly : gdly2, first ? v.rdly : rdly2,
                first ? v.rdata : rd2, v.late_d && first);
         last_d = wd;
         first  = 1'b0;
      end
      chk("reqs_drained", {if_req, d_req}, 2'b00);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1, 0, 0, 32'h10,  32'h0,   32'h0,        4'h0, 0, 2, 32'h00500093, 0, 0};
      vecs[1] = '{1, 1, 1, 32'h0,   32'h100, 32'hDEADBEEF, 4'hF, 1, 1, 32'h11111111, 0, !RR || !last_d};
      vecs[2] = '{1, 0, 0, 32'h200, 32'h300, 32'h0,        4'h3, 3, 3, 32'hCAFEF00D, 1, 0};
      vecs[3] = '{0, 1, 0, 32'h0,   32'h44,  32'h0,        4'hF, 0, 6, 32'h12345678, 0, 1};
      vecs[4] = '{1, 0, 0, 32'h80,  32'h0,   32'h0,        4'h0, 2, TO, 32'hA5A5A5A5, 0, 0};
      vecs[5] = '{0, 1, 1, 32'h0,   32'h500, 32'h0BADCAFE, 4'h5, 0, TO + 1, 32'h0, 0, 1};

      reset = 1'b0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         {if_req, d_req, d_we, mem_gnt, mem_rvalid} = 5'($urandom);
         if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
         mem_rdata = $urandom;
         #1;
         chk("rst_outs_zero", {if_gnt, if_rvalid, d_gnt, d_rvalid, rsp_err, mem_req, mem_we, busy}, 8'h0);
         chk("rst_buses_zero", if_rdata | d_rdata | mem_addr | mem_wdata | {28'h0, mem_be}, 32'h0);
      end
      @(negedge clk);
      {if_req, d_req, mem_gnt, mem_rvalid} = 4'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1 chk("idle_no_req", {busy, mem_req}, 2'b00);

      for (int i = 0; i < 6; i++)
         run_vec(vecs[i], 0, 2, 32'h0F0F0F0F);

      // Reset in WAIT aborts; a response arriving afterwards must not pulse.
      if_req = 1; if_addr = 32'h40;
      @(negedge clk);
      mem_gnt = 1;
      #1 chk("abort_gnt", if_gnt, 1'b1);
      @(negedge clk);
      mem_gnt = 0; if_req = 0;
      #1 chk("abort_in_wait", busy, 1'b1);
      reset = 1'b0;
      #1 chk("abort_rst", {busy, if_rvalid, d_rvalid}, 3'b0);
      @(negedge clk);
      reset = 1'b1; mem_rvalid = 1; mem_rdata = 32'h55;
      #1 chk("abort_late_rsp", {busy, if_rvalid, d_rvalid, rsp_err}, 4'b0);
      @(negedge clk);
      mem_rvalid = 0;
      last_d = 1'b0;

      for (int r = 0; r < 40; r++) begin
         vec_t v;
         bit ir, dr;
         do begin ir = 1'($urandom); dr = 1'($urandom); end while (!ir && !dr);
         v.if_r = ir; v.d_r = dr; v.d_we = 1'($urandom);
         v.if_addr = $urandom; v.d_addr = $urandom; v.d_wdata = $urandom; v.d_be = 4'($urandom);
         v.gdly = $urandom_range(0, 3); v.rdly = $urandom_range(1, TO + 2);
         v.rdata = $urandom; v.late_d = 1'b0;
         v.exp_first_d = pick_d(ir, dr, last_d);
         run_vec(v, $urandom_range(0, 3), $urandom_range(1, TO + 2), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
